// File: rtl/pll_cfg_pkg.sv
// Shared constants, state encoding and counter-word packing for the PLL
// reconfiguration sequencer.
package pll_cfg_pkg;

    localparam logic [5:0] REG_MODE   = 6'd0;
    localparam logic [5:0] REG_STATUS = 6'd1;
    localparam logic [5:0] REG_START  = 6'd2;
    localparam logic [5:0] REG_N      = 6'd3;
    localparam logic [5:0] REG_M      = 6'd4;
    localparam logic [5:0] REG_C      = 6'd5;
    localparam logic [5:0] REG_K      = 6'd7;

    localparam logic [31:0] K_PAL_DEF  = 32'd343817200;
    localparam logic [31:0] K_NTSC_DEF = 32'd702807833;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_SETTLE,
        S_LOCKWAIT,
        S_FIN
    } state_t;

    // Counter register layout: sel[22:18], odd[17], bypass[16], hi[15:8], lo[7:0].
    function automatic logic [31:0] cnt_word(input logic [4:0] sel, input logic odd,
                                             input logic bypass, input logic [7:0] hi,
                                             input logic [7:0] lo);
        return {9'd0, sel, odd, bypass, hi, lo};
    endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchroniser for the asynchronous PLL lock indication.
module pll_lock_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);
    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            dout <= 1'b0;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end
endmodule

// File: rtl/pll_cfg_seq.sv
// PAL/NTSC PLL reconfiguration sequencer: walks a fixed management-port write
// list, then waits out a settle window and PLL relock (with timeout).
module pll_cfg_seq
    import pll_cfg_pkg::*;
#(
    parameter logic [31:0] K_PAL        = K_PAL_DEF,
    parameter logic [31:0] K_NTSC       = K_NTSC_DEF,
    parameter int          SETTLE_CYC   = 64,
    parameter int          LOCK_TIMEOUT = 1048576
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_req,
    input  logic        cfg_ntsc,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        cfg_cur,
    output logic [5:0]  mgmt_address,
    output logic        mgmt_write,
    output logic [31:0] mgmt_writedata,
    output logic        mgmt_read,
    input  logic        mgmt_waitrequest,
    input  logic        pll_locked
);
    localparam int CNT_MAX = (LOCK_TIMEOUT > SETTLE_CYC) ? LOCK_TIMEOUT : SETTLE_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_TIMEOUT - 1);

    state_t        state, state_nxt;
    logic [2:0]    idx, idx_nxt;
    logic          gap, gap_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          prof, prof_nxt;
    logic          err_nxt, cur_nxt;
    logic          locked;
    logic [5:0]    rom_addr;
    logic [31:0]   rom_data;

    pll_lock_sync u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (pll_locked),
        .dout  (locked)
    );

    // Write list; only the K word depends on the latched profile.
    always_comb begin
        rom_addr = REG_MODE;
        rom_data = 32'd0;
        case (idx)
            3'd0: begin rom_addr = REG_MODE;  rom_data = 32'd0; end
            3'd1: begin rom_addr = REG_N;     rom_data = cnt_word(5'd0, 1'b0, 1'b1, 8'd0, 8'd0); end
            3'd2: begin rom_addr = REG_M;     rom_data = cnt_word(5'd0, 1'b1, 1'b0, 8'd5, 8'd4); end
            3'd3: begin rom_addr = REG_C;     rom_data = cnt_word(5'd0, 1'b0, 1'b0, 8'd2, 8'd2); end
            3'd4: begin rom_addr = REG_C;     rom_data = cnt_word(5'd1, 1'b0, 1'b0, 8'd8, 8'd8); end
            3'd5: begin rom_addr = REG_K;     rom_data = prof ? K_NTSC : K_PAL; end
            3'd6: begin rom_addr = REG_START; rom_data = 32'd0; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            idx     <= '0;
            gap     <= 1'b0;
            cnt     <= '0;
            prof    <= 1'b0;
            err     <= 1'b0;
            cfg_cur <= 1'b0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            gap     <= gap_nxt;
            cnt     <= cnt_nxt;
            prof    <= prof_nxt;
            err     <= err_nxt;
            cfg_cur <= cur_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        idx_nxt        = idx;
        gap_nxt        = gap;
        cnt_nxt        = cnt;
        prof_nxt       = prof;
        err_nxt        = err;
        cur_nxt        = cfg_cur;
        busy           = (state == S_WRITE) || (state == S_SETTLE) || (state == S_LOCKWAIT);
        done           = 1'b0;
        mgmt_write     = 1'b0;
        mgmt_address   = '0;
        mgmt_writedata = '0;
        mgmt_read      = 1'b0;
        case (state)
            S_IDLE: begin
                if (cfg_req) begin
                    prof_nxt  = cfg_ntsc;
                    err_nxt   = 1'b0;
                    idx_nxt   = '0;
                    gap_nxt   = 1'b0;
                    state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                if (!gap) begin
                    mgmt_write     = 1'b1;
                    mgmt_address   = rom_addr;
                    mgmt_writedata = rom_data;
                    if (!mgmt_waitrequest) gap_nxt = 1'b1;
                end else begin
                    // Mandatory idle cycle between writes; advance afterwards.
                    gap_nxt = 1'b0;
                    if (idx == 3'd6) begin
                        idx_nxt   = '0;
                        cnt_nxt   = '0;
                        state_nxt = S_SETTLE;
                    end else begin
                        idx_nxt = idx + 3'd1;
                    end
                end
            end
            S_SETTLE: begin
                if (cnt == SETTLE_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = S_LOCKWAIT;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_LOCKWAIT: begin
                if (locked) begin
                    state_nxt = S_FIN;
                end else if (cnt == LOCK_LAST) begin
                    err_nxt   = 1'b1;
                    state_nxt = S_FIN;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_FIN: begin
                done      = 1'b1;
                cur_nxt   = prof;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_pll_cfg_seq.sv
// Self-checking bench for pll_cfg_seq: scenario table, randomized stall/profile
// runs against a list-level model, and hand-written reset/back-to-back cases.
module tb_pll_cfg_seq;
    localparam int S  = 8;
    localparam int TO = 100;
    localparam logic [31:0] KP = 32'd343817200;
    localparam logic [31:0] KN = 32'd702807833;

    logic        clk = 1'b0, rst_n = 1'b0, cfg_req = 1'b0, cfg_ntsc = 1'b0;
    logic        mgmt_waitrequest = 1'b0, pll_locked = 1'b0;
    logic        busy, done, err, cfg_cur, mgmt_write, mgmt_read;
    logic [5:0]  mgmt_address;
    logic [31:0] mgmt_writedata;

    pll_cfg_seq #(.K_PAL(KP), .K_NTSC(KN), .SETTLE_CYC(S), .LOCK_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_req(cfg_req), .cfg_ntsc(cfg_ntsc),
        .busy(busy), .done(done), .err(err), .cfg_cur(cfg_cur),
        .mgmt_address(mgmt_address), .mgmt_write(mgmt_write),
        .mgmt_writedata(mgmt_writedata), .mgmt_read(mgmt_read),
        .mgmt_waitrequest(mgmt_waitrequest), .pll_locked(pll_locked)
    );

    always #5 clk = ~clk;

    int nvec = 0, nerr = 0;
    int pc = 0;
    always @(posedge clk) pc <= pc + 1;

    typedef struct {
        logic        ntsc;
        int          stall;
        int          lock_mode;   // 0 never locks, 1 locked throughout, 2 locks after settle
        bit          disturb;
        logic [31:0] exp_k;
        logic        exp_err;
        logic        exp_cur;
        string       name;
    } vec_t;

    // Controller responder and bus monitor; everything is observed mid-cycle.
    int          stall_cfg = 0, stall_left = 0;
    bit          rand_stall = 1'b0, prev_write = 1'b0;
    int          done_cnt = 0, done_cyc = -1;
    int          ws[$], wc[$];
    logic [5:0]  wa[$];
    logic [31:0] wd[$];

    always @(negedge clk) begin
        if (!mgmt_write) begin
            mgmt_waitrequest = 1'b0;
            stall_left = rand_stall ? int'($urandom_range(0, 3)) : stall_cfg;
        end else if (stall_left > 0) begin
            mgmt_waitrequest = 1'b1;
            stall_left--;
        end else begin
            mgmt_waitrequest = 1'b0;
        end
        if (mgmt_write && !prev_write) ws.push_back(pc);
        if (mgmt_write && !mgmt_waitrequest) begin
            wc.push_back(pc);
            wa.push_back(mgmt_address);
            wd.push_back(mgmt_writedata);
        end
        if (done) begin
            done_cnt++;
            done_cyc = pc;
        end
        prev_write = mgmt_write;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Expected management transaction i, straight from the write list.
    function automatic logic [37:0] exp_wr(input int i, input logic [31:0] k);
        case (i)
            0:       return {6'd0, 32'h0000_0000};
            1:       return {6'd3, 32'h0001_0000};
            2:       return {6'd4, 32'h0002_0504};
            3:       return {6'd5, 32'h0000_0202};
            4:       return {6'd5, 32'h0004_0808};
            5:       return {6'd7, k};
            default: return {6'd2, 32'h0000_0000};
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear();
        ws.delete(); wc.delete(); wa.delete(); wd.delete();
        done_cnt = 0;
        done_cyc = -1;
    endtask

    task automatic request(input logic ntsc, output int rc);
        @(posedge clk); #1;
        cfg_req = 1'b1; cfg_ntsc = ntsc; rc = pc;
        @(posedge clk); #1;
        cfg_req = 1'b0; cfg_ntsc = ~ntsc;
    endtask

    task automatic wait_writes(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #1;
            if (wc.size() >= n) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #1;
            if (done_cnt > 0) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_until(input int t);
        for (int i = 0; i < 5000 && pc < t; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic run_seq(input vec_t v);
        int rc, wc6, exp_done, bad;
        bit ok;
        clear();
        stall_cfg  = (v.stall < 0) ? 0 : v.stall;
        rand_stall = (v.stall < 0);
        pll_locked = (v.lock_mode == 1);
        request(v.ntsc, rc);
        chk({v.name, "_busy_acc"}, busy, 1);
        chk({v.name, "_err_acc"}, err, 0);
        if (v.disturb) begin
            wait_writes(3, ok);
            for (int i = 0; i < 4; i++) begin
                @(posedge clk); #1;
                cfg_req = (i % 2 == 0);
                cfg_ntsc = ~cfg_ntsc;
            end
            @(posedge clk); #1;
            cfg_req = 1'b0;
        end
        wait_writes(7, ok);
        chk({v.name, "_writes_seen"}, ok, 1);
        wc6 = (wc.size() >= 7) ? wc[6] : -1000;
        if (ok && v.lock_mode == 2) begin
            wait_until(wc6 + S + 2);
            pll_locked = 1'b1;
        end
        wait_done(ok);
        chk({v.name, "_done_seen"}, ok, 1);
        repeat (5) @(negedge clk);
        #1;
        chk({v.name, "_nwr"}, wc.size(), 7);
        for (int i = 0; i < 7 && i < wc.size(); i++)
            chk($sformatf("%s_wr%0d", v.name, i), {wa[i], wd[i]}, exp_wr(i, v.exp_k));
        case (v.lock_mode)
            0:       exp_done = wc6 + S + 2 + TO;
            1:       exp_done = wc6 + S + 3;
            default: exp_done = wc6 + S + 5;
        endcase
        chk({v.name, "_done_cyc"}, done_cyc, exp_done);
        chk({v.name, "_done_cnt"}, done_cnt, 1);
        chk({v.name, "_err"}, err, v.exp_err);
        chk({v.name, "_cur"}, cfg_cur, v.exp_cur);
        chk({v.name, "_busy_end"}, busy, 0);
        chk({v.name, "_first_wr"}, (ws.size() > 0) ? ws[0] : -1, rc + 1);
        bad = (ws.size() == 7 && wc.size() == 7) ? 0 : 1;
        for (int i = 0; i < 6 && i + 1 < ws.size() && i < wc.size(); i++)
            if (ws[i + 1] - wc[i] != 2) bad++;
        for (int i = 0; i < 7 && i < ws.size() && i < wc.size(); i++)
            if (!rand_stall && (wc[i] - ws[i] != v.stall)) bad++;
        chk({v.name, "_gap_stall"}, bad, 0);
    endtask

    initial begin
        vec_t tbl[5];
        vec_t rv;
        int   rc, t;
        bit   ok;

        tbl[0] = '{1'b0, 2, 2, 1'b0, KP, 1'b0, 1'b0, "pal_stall2"};
        tbl[1] = '{1'b1, 0, 1, 1'b0, KN, 1'b0, 1'b1, "ntsc_nostall"};
        tbl[2] = '{1'b0, 1, 0, 1'b0, KP, 1'b1, 1'b0, "pal_timeout"};
        tbl[3] = '{1'b1, 3, 2, 1'b0, KN, 1'b0, 1'b1, "ntsc_after_to"};
        tbl[4] = '{1'b0, 0, 1, 1'b1, KP, 1'b0, 1'b0, "pal_disturbed"};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_cur", cfg_cur, 0);
        chk("rst_write", mgmt_write, 0);
        chk("rst_addr", mgmt_address, 0);
        chk("rst_data", mgmt_writedata, 0);
        chk("rst_read", mgmt_read, 0);
        rst_n = 1'b1;

        foreach (tbl[i]) run_seq(tbl[i]);

        for (int n = 0; n < 6; n++) begin
            rv.ntsc      = 1'($urandom % 2);
            rv.stall     = -1;
            rv.lock_mode = 1 + int'($urandom % 2);
            rv.disturb   = 1'b0;
            rv.exp_k     = rv.ntsc ? KN : KP;
            rv.exp_err   = 1'b0;
            rv.exp_cur   = rv.ntsc;
            rv.name      = $sformatf("rand%0d", n);
            run_seq(rv);
        end

        // Request held through FIN and the next cycle: only the IDLE cycle accepts.
        clear();
        stall_cfg = 0; rand_stall = 1'b0; pll_locked = 1'b1;
        request(1'b0, rc);
        wait_writes(7, ok);
        chk("b2b_writes_seen", ok, 1);
        t = (wc.size() >= 7) ? wc[6] + S + 3 : pc + 2;
        wait_until(t);
        cfg_req = 1'b1; cfg_ntsc = 1'b1;
        @(posedge clk); #1;
        chk("b2b_done_cyc", done_cyc, t);
        chk("b2b_done_cnt", done_cnt, 1);
        clear();
        @(posedge clk); #1;
        cfg_req = 1'b0; cfg_ntsc = 1'b0;
        wait_done(ok);
        chk("b2b_done2_seen", ok, 1);
        chk("b2b_accept_cyc", (ws.size() > 0) ? ws[0] : -1, t + 2);
        chk("b2b_k", (wd.size() >= 6) ? wd[5] : 32'd0, KN);
        repeat (2) @(negedge clk);
        #1;
        chk("b2b_cur", cfg_cur, 1);

        // Reset in the middle of a stalled write 3.
        clear();
        stall_cfg = 5; rand_stall = 1'b0; pll_locked = 1'b0;
        request(1'b0, rc);
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk); #1;
            if (wc.size() == 3 && mgmt_write && mgmt_waitrequest) begin ok = 1'b1; break; end
        end
        chk("rst_mid_reach", ok, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_write", mgmt_write, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_addr", mgmt_address, 0);
        chk("rst_mid_data", mgmt_writedata, 0);
        chk("rst_mid_cur", cfg_cur, 0);
        chk("rst_mid_err", err, 0);
        chk("rst_mid_done", done, 0);
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_mid_no_wr", wc.size(), 3);
        rv = '{1'b0, 0, 1, 1'b0, KP, 1'b0, 1'b0, "pal_after_rst"};
        run_seq(rv);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
